// File: rtl/rom_arbiter.sv
// rom_arbiter
//
// Shares one synchronous single-port ROM (registered read with clock enable)
// between two read requesters. Each request is served as a four-cycle
// transaction: grant (IDLE), ROM access (READ), data capture (CAPT) and a
// one-cycle completion pulse (ACK). Contention is settled round-robin, and no
// new grant is issued while the ROM reports that its contents are not loaded.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   r0_req / r0_addr    port 0 request (held until r0_ack) and word address
//   r0_ack / r0_data    port 0 completion pulse and captured read data
//   r1_req / r1_addr    port 1 request and word address
//   r1_ack / r1_data    port 1 completion pulse and captured read data
//   rom_ready           ROM contents loaded; grants are blocked while low
//   rom_ce / rom_a      ROM clock enable and address, owned by the arbiter
//   rom_q               ROM registered read data
module rom_arbiter #(
  parameter int DW = 8,
  parameter int AW = 14
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          r0_req,
  input  logic [AW-1:0] r0_addr,
  output logic          r0_ack,
  output logic [DW-1:0] r0_data,
  input  logic          r1_req,
  input  logic [AW-1:0] r1_addr,
  output logic          r1_ack,
  output logic [DW-1:0] r1_data,
  input  logic          rom_ready,
  output logic          rom_ce,
  output logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_q
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPT,
    ACK
  } state_t;

  state_t state;
  state_t state_next;

  // sel: port owning the transaction in flight; last: port granted most recently
  logic sel;
  logic last;
  logic grant;
  logic winner;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant decision is made only in IDLE. With both ports asking, the port that
  // was not served last wins, so sustained contention alternates 0,1,0,1.
  // The reset value last=1 lets port 0 win the first tie.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    winner     = 1'b0;
    case (state)
      IDLE: begin
        if (rom_ready && (r0_req || r1_req)) begin
          grant      = 1'b1;
          winner     = (r0_req && r1_req) ? ~last : r1_req;
          state_next = READ;
        end
      end
      READ:    state_next = CAPT;
      CAPT:    state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. The address is latched at grant and held afterwards, so later
  // address changes by the requester have no effect. rom_ce follows grant by
  // one edge, which keeps it high for exactly the READ cycle. Only the
  // selected port's data/ack registers are written in CAPT; the other port's
  // results stay untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rom_ce  <= 1'b0;
      rom_a   <= '0;
      sel     <= 1'b0;
      last    <= 1'b1;
      r0_ack  <= 1'b0;
      r1_ack  <= 1'b0;
      r0_data <= '0;
      r1_data <= '0;
    end else begin
      rom_ce <= grant;
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      if (grant) begin
        rom_a <= winner ? r1_addr : r0_addr;
        sel   <= winner;
        last  <= winner;
      end
      if (state == CAPT) begin
        if (sel) begin
          r1_data <= rom_q;
          r1_ack  <= 1'b1;
        end else begin
          r0_data <= rom_q;
          r0_ack  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares one synchronous single-port ROM between two read requesters, e.g. CPU BIOS fetch (port 0) and a boot/shadow copier (port 1).
- ROM model: registered read with clock enable; data is valid the cycle after the ce-qualified edge.
- The arbiter owns the ROM's ce and address, captures returned data per port and completes each request with a one-cycle ack.
- Grants are withheld until the ROM reports its contents loaded.

Parameters:
DW, 8, ROM data width
AW, 14, ROM address width (2**AW words)

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
r0_req  in  1  port 0 read request; held high until r0_ack
r0_addr  in  AW  port 0 word address; sampled at grant only
r0_ack  out  1  port 0 completion, one-cycle pulse
r0_data  out  DW  port 0 read data; valid from the r0_ack cycle, held until the next r0_ack
r1_req  in  1  port 1 read request
r1_addr  in  AW  port 1 word address
r1_ack  out  1  port 1 completion pulse
r1_data  out  DW  port 1 read data
rom_ready  in  1  ROM contents loaded (bios_loaded); no grant while low
rom_ce  out  1  ROM clock enable
rom_a  out  AW  ROM address
rom_q  in  DW  ROM registered read data

Behaviour:
- Reset (async, active-high):
  - State IDLE; rom_ce=0, rom_a=0.
  - r0_ack=r1_ack=0; r0_data=r1_data=0.
  - Round-robin pointer last=1, so port 0 wins the first tie.
- FSM states: IDLE, READ, CAPT, ACK.
- IDLE:
  - If rom_ready=1 and any req is high, grant at this edge.
  - The winner's address goes to rom_a, rom_ce<=1, sel<=winner, last<=winner, next state READ.
  - Otherwise stay in IDLE with rom_ce=0.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port not equal to last wins (strict alternation under contention).
- READ (one cycle):
  - rom_ce=1 with the latched rom_a, so the ROM captures at this edge.
  - Next edge: rom_ce<=0, next state CAPT.
- CAPT:
  - rom_q is valid.
  - At the edge: r<sel>_data<=rom_q, r<sel>_ack<=1, next state ACK.
- ACK (one cycle):
  - r<sel>_ack=1 for exactly this cycle.
  - Next edge: ack<=0, next state IDLE.
  - The requester drops req, or presents a new request, at the edge that samples ack.
- Latency: req sampled in IDLE at edge E0 -> ack high in the cycle after E2, i.e. 3 cycles. Peak throughput is 1 read per 4 cycles.
- rom_a holds its last value outside READ. rom_ce is high only in READ; exactly one cycle per transaction.
- The non-selected port's data and ack are never modified by another port's transaction.
- Boundary cases:
  - Address change after grant: ignored; the latched address is used.
  - req dropped mid-transaction: the transaction completes, and data and ack still update and pulse. A request cannot be cancelled.
  - rom_ready low mid-transaction: the transaction completes; only new grants are blocked.
  - Both reqs held continuously: grants alternate 0,1,0,1 after reset.
  - New req in the ACK cycle: considered at the next IDLE evaluation.
  - Reset mid-transaction: immediate return to the reset state. ack is not pulsed, and captured data returns to 0.
  - Address wrap: none. The full 0..2**AW-1 range is passed through unmodified.

Test Plan:
- rom_ready=0, r0_req=1 for 20 cycles -> rom_ce never high, no ack. Raise rom_ready -> r0_ack pulses 3 cycles later.
- ROM preloaded d[16'h0005]=8'hA5; r0 reads address 5 -> rom_a=5, rom_ce high exactly one cycle, r0_ack one cycle with r0_data=8'hA5; r1_data stays 0.
- r0 and r1 asserted together after reset with addresses 1 and 2 (d=8'h11, 8'h22) -> r0 served first (r0_data=8'h11), then r1 (r1_data=8'h22); the acks are 4 cycles apart.
- Both reqs held for 8 transactions -> ack order 0,1,0,1,0,1,0,1.
- r1 granted for address 3, r1_addr changed to 7 in the READ cycle -> r1_data=d[3].
- Assert reset during CAPT -> all outputs 0 asynchronously and no ack. After release, a fresh r0 request completes normally.
